// File: rtl/vx_alu_batch.sv
// rtl/vx_alu_batch.sv - warp ALU that evaluates SIMD_WIDTH lanes per cycle, plus warp vote ops
// Accepts one request at a time, results held in DONE until the consumer takes them.
module vx_alu_batch #(
   parameter int NUM_LANES  = 8,
   parameter int SIMD_WIDTH = 2,
   parameter int XLEN       = 32,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                in_op,
   input  logic [NUM_LANES-1:0]      in_tmask,
   input  logic [NUM_LANES*XLEN-1:0] in_rs1,
   input  logic [NUM_LANES*XLEN-1:0] in_rs2,
   input  logic [TAG_WIDTH-1:0]      in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_LANES*XLEN-1:0] out_data,
   output logic [NUM_LANES-1:0]      out_tmask,
   output logic [TAG_WIDTH-1:0]      out_tag
);

   generate
      if (NUM_LANES % SIMD_WIDTH != 0) begin : g_bad_simd
         $error("NUM_LANES must be a multiple of SIMD_WIDTH");
      end
   endgenerate

   localparam int NUM_BATCHES = NUM_LANES / SIMD_WIDTH;
   localparam int CNT_W       = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
   localparam int SH_W        = $clog2(XLEN);
   localparam int BAL_W       = (NUM_LANES < XLEN) ? NUM_LANES : XLEN;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BATCHES - 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_VALL = 4'd10;
   localparam logic [3:0] OP_VANY = 4'd11;
   localparam logic [3:0] OP_VUNI = 4'd12;
   localparam logic [3:0] OP_VBAL = 4'd13;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [3:0]                op_q, op_d;
   logic [NUM_LANES-1:0]      tmask_q, tmask_d;
   logic [NUM_LANES*XLEN-1:0] rs1_q, rs1_d;
   logic [NUM_LANES*XLEN-1:0] rs2_q, rs2_d;
   logic [TAG_WIDTH-1:0]      tag_q, tag_d;
   logic [NUM_LANES*XLEN-1:0] res_q, res_d;
   logic [NUM_LANES-1:0]      vote_true_q, vote_true_d;
   logic [NUM_LANES-1:0]      vote_false_q, vote_false_d;

   logic                      is_vote;
   logic                      vote_all;
   logic                      vote_any;
   logic [XLEN-1:0]           bal;
   logic [XLEN-1:0]           vote_word;
   int                        base;
   int                        lane;

   // Vote opcodes yield 0 here; their lanes are filled once all batches are seen.
   function automatic logic [XLEN-1:0] lane_alu(input logic [3:0]      op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [SH_W-1:0] sh;
      logic [XLEN-1:0] r;
      sh = b[SH_W-1:0];
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = $unsigned($signed(a) >>> sh);
         default: r = '0;
      endcase
      return r;
   endfunction

   assign is_vote = (op_q >= OP_VALL) && (op_q <= OP_VBAL);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      tmask_d      = tmask_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      tag_d        = tag_q;
      res_d        = res_q;
      vote_true_d  = vote_true_q;
      vote_false_d = vote_false_q;
      vote_all     = 1'b0;
      vote_any     = 1'b0;
      bal          = '0;
      vote_word    = '0;
      base         = 0;
      lane         = 0;
      in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);

      case (state_q)
         BUSY: begin
            base = int'(cnt_q) * SIMD_WIDTH;
            for (int j = 0; j < SIMD_WIDTH; j++) begin
               lane = base + j;
               res_d[lane*XLEN +: XLEN] = tmask_q[lane]
                  ? lane_alu(op_q, rs1_q[lane*XLEN +: XLEN], rs2_q[lane*XLEN +: XLEN])
                  : '0;
               vote_true_d[lane]  = vote_true_q[lane]  | (tmask_q[lane] &  rs1_q[lane*XLEN]);
               vote_false_d[lane] = vote_false_q[lane] | (tmask_q[lane] & ~rs1_q[lane*XLEN]);
            end

            // Uses the _d flags so the final batch contributes to the vote.
            vote_all = ~|vote_false_d;
            vote_any = |vote_true_d;
            for (int i = 0; i < BAL_W; i++) bal[i] = vote_true_d[i];
            case (op_q)
               OP_VALL: vote_word = {{(XLEN-1){1'b0}}, vote_all};
               OP_VANY: vote_word = {{(XLEN-1){1'b0}}, vote_any};
               OP_VUNI: vote_word = {{(XLEN-1){1'b0}}, (vote_all | ~vote_any)};
               OP_VBAL: vote_word = bal;
               default: vote_word = '0;
            endcase

            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               if (is_vote) begin
                  for (int i = 0; i < NUM_LANES; i++)
                     res_d[i*XLEN +: XLEN] = tmask_q[i] ? vote_word : '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: ;
      endcase

      // Acceptance overrides DONE->IDLE so a fire+accept cycle goes straight to BUSY.
      if (in_valid && in_ready) begin
         state_d      = BUSY;
         cnt_d        = '0;
         op_d         = in_op;
         tmask_d      = in_tmask;
         rs1_d        = in_rs1;
         rs2_d        = in_rs2;
         tag_d        = in_tag;
         vote_true_d  = '0;
         vote_false_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         tmask_q      <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         tag_q        <= '0;
         res_q        <= '0;
         vote_true_q  <= '0;
         vote_false_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         tmask_q      <= tmask_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         tag_q        <= tag_d;
         res_q        <= res_d;
         vote_true_q  <= vote_true_d;
         vote_false_q <= vote_false_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign out_data  = res_q;
   assign out_tmask = tmask_q;
   assign out_tag   = tag_q;

endmodule

// File: tb/tb_vx_alu_batch.sv
// tb/tb_vx_alu_batch.sv - directed self-checking bench for vx_alu_batch
module tb_vx_alu_batch;
   localparam int NL = 4;
   localparam int SW = 2;
   localparam int XL = 32;
   localparam int TW = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b1;
   logic [3:0]       in_op = '0;
   logic [NL-1:0]    in_tmask = '0;
   logic [NL*XL-1:0] in_rs1 = '0;
   logic [NL*XL-1:0] in_rs2 = '0;
   logic [TW-1:0]    in_tag = '0;

   logic             in_ready, out_valid;
   logic [NL*XL-1:0] out_data;
   logic [NL-1:0]    out_tmask;
   logic [TW-1:0]    out_tag;
   logic             f_in_ready, f_out_valid;
   logic [NL*XL-1:0] f_out_data;
   logic [NL-1:0]    f_out_tmask;
   logic [TW-1:0]    f_out_tag;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vx_alu_batch #(.NUM_LANES(NL), .SIMD_WIDTH(SW), .XLEN(XL), .TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_tmask(in_tmask), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tmask(out_tmask), .out_tag(out_tag));

   vx_alu_batch #(.NUM_LANES(NL), .SIMD_WIDTH(NL), .XLEN(XL), .TAG_WIDTH(TW)) dut_full (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(f_in_ready),
      .in_op(in_op), .in_tmask(in_tmask), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
      .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
      .out_tmask(f_out_tmask), .out_tag(f_out_tag));

   task automatic drive(input logic [3:0] op, input logic [NL-1:0] tm,
                        input logic [NL*XL-1:0] a, input logic [NL*XL-1:0] b, input logic [TW-1:0] tag);
      in_op = op; in_tmask = tm; in_rs1 = a; in_rs2 = b; in_tag = tag;
   endtask

   // Issues one request from IDLE; lat counts edges from the accept edge to out_valid.
   task automatic run_req(input logic [3:0] op, input logic [NL-1:0] tm,
                          input logic [NL*XL-1:0] a, input logic [NL*XL-1:0] b,
                          input logic [TW-1:0] tag, output int lat);
      @(negedge clk);
      drive(op, tm, a, b, tag);
      in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      #1 in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      n_checks++; if (out_data !== '0 || out_tmask !== '0 || out_tag !== '0) begin n_fail++; $display("FAIL reset_out: data=%h tmask=%b tag=%h want 0", out_data, out_tmask, out_tag); end
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold: out_valid=%b want 0", out_valid); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_add();
      int lat;
      run_req(4'd0, 4'b1111, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 8'hA5, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", lat); end
      n_checks++; if (out_data !== {32'd0, 32'd4, 32'd3, 32'd2}) begin n_fail++; $display("FAIL add_data: got %h want %h", out_data, {32'd0, 32'd4, 32'd3, 32'd2}); end
      n_checks++; if (out_tag !== 8'hA5 || out_tmask !== 4'b1111) begin n_fail++; $display("FAIL add_tag: tag=%h tmask=%b want a5/1111", out_tag, out_tmask); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_done_ready: in_ready=%b want 1", in_ready); end
      drain();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL add_to_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_arith_logic();
      int lat;
      run_req(4'd1, 4'b1111, {32'd0, 32'd10, 32'd5, 32'd0}, {32'd1, 32'd3, 32'd5, 32'd1}, 8'h01, lat);
      n_checks++; if (out_data !== {32'hFFFFFFFF, 32'd7, 32'd0, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL sub_data: got %h", out_data); end
      drain();
      run_req(4'd4, 4'b0110, {32'hF0F0F0F0, 32'h12345678, 32'hFFFF0000, 32'hAAAAAAAA},
              {32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0000FFFF, 32'h55555555}, 8'h02, lat);
      n_checks++; if (out_data !== {32'd0, 32'hEDCBA987, 32'hFFFFFFFF, 32'd0}) begin n_fail++; $display("FAIL xor_masked: got %h", out_data); end
      drain();
      run_req(4'd15, 4'b1111, {4{32'h12345678}}, {4{32'h9ABCDEF0}}, 8'h03, lat);
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL op15_zero: got %h want 0", out_data); end
      drain();
   endtask

   task automatic test_compare_shift();
      int lat;
      run_req(4'd5, 4'b0001, {4{32'hFFFFFFFF}}, {4{32'd1}}, 8'h10, lat);
      n_checks++; if (out_data !== {32'd0, 32'd0, 32'd0, 32'd1}) begin n_fail++; $display("FAIL slt: got %h want lane0=1", out_data); end
      drain();
      run_req(4'd6, 4'b0001, {4{32'hFFFFFFFF}}, {4{32'd1}}, 8'h11, lat);
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL sltu: got %h want 0", out_data); end
      drain();
      run_req(4'd9, 4'b0011, {32'h80000000, 32'h80000000, 32'h7FFFFFF0, 32'h80000000},
              {32'd0, 32'd0, 32'd4, 32'd36}, 8'h12, lat);
      n_checks++; if (out_data !== {32'd0, 32'd0, 32'h07FFFFFF, 32'hF8000000}) begin n_fail++; $display("FAIL sra: got %h", out_data); end
      drain();
      run_req(4'd7, 4'b0011, {32'd0, 32'd0, 32'd3, 32'h80000000}, {32'd0, 32'd0, 32'd33, 32'd36}, 8'h13, lat);
      n_checks++; if (out_data !== {32'd0, 32'd0, 32'd6, 32'd0}) begin n_fail++; $display("FAIL sll: got %h", out_data); end
      drain();
      run_req(4'd8, 4'b0011, {32'd0, 32'd0, 32'd3, 32'h80000000}, {32'd0, 32'd0, 32'd33, 32'd36}, 8'h14, lat);
      n_checks++; if (out_data !== {32'd0, 32'd0, 32'd1, 32'h08000000}) begin n_fail++; $display("FAIL srl: got %h", out_data); end
      drain();
   endtask

   task automatic test_vote();
      int lat;
      logic [NL*XL-1:0] a;
      a = {32'h3, 32'h5, 32'h2, 32'h1};
      run_req(4'd13, 4'b1011, a, '0, 8'h20, lat);
      n_checks++; if (out_data !== {32'd9, 32'd0, 32'd9, 32'd9}) begin n_fail++; $display("FAIL vote_bal: got %h", out_data); end
      drain();
      run_req(4'd10, 4'b1011, a, '0, 8'h21, lat);
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL vote_all: got %h want 0", out_data); end
      drain();
      run_req(4'd11, 4'b1011, a, '0, 8'h22, lat);
      n_checks++; if (out_data !== {32'd1, 32'd0, 32'd1, 32'd1}) begin n_fail++; $display("FAIL vote_any: got %h", out_data); end
      drain();
      run_req(4'd12, 4'b1011, a, '0, 8'h23, lat);
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL vote_uni_mixed: got %h want 0", out_data); end
      drain();
      run_req(4'd12, 4'b1011, {32'h3, 32'h0, 32'h7, 32'h1}, '0, 8'h24, lat);
      n_checks++; if (out_data !== {32'd1, 32'd0, 32'd1, 32'd1}) begin n_fail++; $display("FAIL vote_uni_agree: got %h", out_data); end
      drain();
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b0;
      run_req(4'd0, 4'b1111, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 8'h5A, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d want 3", lat); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== {32'd0, 32'd4, 32'd3, 32'd2} || out_tag !== 8'h5A || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%h tag=%h in_ready=%b", k, out_valid, out_data, out_tag, in_ready);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      drive(4'd1, 4'b1111, {32'd0, 32'd10, 32'd5, 32'd0}, {32'd1, 32'd3, 32'd5, 32'd1}, 8'h6B);
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: in_ready=%b want 1", in_ready); end
      @(posedge clk);
      lat = 1;
      #1 in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: out_valid=%b want 0", out_valid); end
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d want 3", lat); end
      n_checks++; if (out_data !== {32'hFFFFFFFF, 32'd7, 32'd0, 32'hFFFFFFFF} || out_tag !== 8'h6B) begin n_fail++; $display("FAIL b2b_data: data=%h tag=%h", out_data, out_tag); end
      drain();
   endtask

   task automatic test_full_width();
      @(negedge clk);
      drive(4'd4, 4'b0110, {32'hF0F0F0F0, 32'h12345678, 32'hFFFF0000, 32'hAAAAAAAA},
            {32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0000FFFF, 32'h55555555}, 8'h77);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_checks++; if (f_out_valid !== 1'b0 || f_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_busy: out_valid=%b in_ready=%b want 0/0", f_out_valid, f_in_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (f_out_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency: out_valid=%b want 1 at latency 2", f_out_valid); end
      n_checks++; if (f_out_data !== {32'd0, 32'hEDCBA987, 32'hFFFFFFFF, 32'd0} || f_out_tag !== 8'h77) begin n_fail++; $display("FAIL full_data: data=%h tag=%h", f_out_data, f_out_tag); end
      repeat (2) drain();
   endtask

   task automatic test_reset_abort();
      int lat;
      logic seen;
      @(negedge clk);
      drive(4'd0, 4'b1111, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 8'h33);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      n_checks++; if (out_data !== '0 || out_tag !== '0) begin n_fail++; $display("FAIL abort_clear: data=%h tag=%h want 0", out_data, out_tag); end
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: out_valid seen=%b want 0", seen); end
      run_req(4'd0, 4'b1111, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 8'h44, lat);
      n_checks++; if (lat !== 3 || out_data !== {32'd0, 32'd4, 32'd3, 32'd2} || out_tag !== 8'h44) begin n_fail++; $display("FAIL abort_recover: lat=%0d data=%h tag=%h", lat, out_data, out_tag); end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_arith_logic();
      test_compare_shift();
      test_vote();
      test_back_to_back();
      test_full_width();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vx_alu_batch.md
VX_ALU_BATCH -- requirements
Module: VX_alu_batch

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8: warp lanes per request.
REQ-002 SHALL have parameter SIMD_WIDTH, default 2: lanes computed per cycle; elaboration SHALL fail unless NUM_LANES % SIMD_WIDTH == 0.
REQ-003 SHALL have parameter XLEN, default 32: operand width.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: opaque request tag width.
REQ-005 SHALL have port clk, input, 1: sole clock; all state rising-edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have port in_valid, input, 1: request valid.
REQ-008 SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready.
REQ-009 SHALL have port in_op, input, 4: opcode.
REQ-010 SHALL have port in_tmask, input, NUM_LANES: active lanes.
REQ-011 SHALL have port in_rs1, input, NUM_LANES*XLEN: operand 1; lane i at [i*XLEN +: XLEN].
REQ-012 SHALL have port in_rs2, input, NUM_LANES*XLEN: operand 2, same packing.
REQ-013 SHALL have port in_tag, input, TAG_WIDTH: returned unchanged.
REQ-014 SHALL have port out_valid, output, 1: result valid.
REQ-015 SHALL have port out_ready, input, 1: consumer ready.
REQ-016 SHALL have port out_data, output, NUM_LANES*XLEN: per-lane results.
REQ-017 SHALL have ports out_tmask (NUM_LANES) and out_tag (TAG_WIDTH), outputs: captured request values.

Function
REQ-018 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 VOTE_ALL, 11 VOTE_ANY, 12 VOTE_UNI, 13 VOTE_BAL; 14-15 SHALL produce 0 in every lane.
REQ-019 Arithmetic SHALL wrap modulo 2^XLEN; shift amount SHALL be rs2[$clog2(XLEN)-1:0]; SLT/SLTU SHALL produce 0 or 1.
REQ-020 FSM states SHALL be IDLE, BUSY and DONE; on acceptance, operands, op, tmask and tag SHALL be registered, and the FSM SHALL enter BUSY with batch counter 0.
REQ-021 In BUSY, each cycle SHALL compute lanes [cnt*SIMD_WIDTH +: SIMD_WIDTH] into the result register, then increment cnt; after batch NUM_LANES/SIMD_WIDTH-1 the FSM SHALL enter DONE.
REQ-022 Each BUSY cycle SHALL OR per-batch flags into vote_true (tmask[i] && rs1[i][0]) and vote_false (tmask[i] && !rs1[i][0]) registers, which SHALL clear on acceptance.
REQ-023 Vote results in DONE: ALL = !|vote_false; ANY = |vote_true; UNI = ALL || !ANY; BAL = vote_true zero-extended to XLEN.
REQ-024 Lanes with tmask[i]=0 SHALL output 0 for every opcode.
REQ-025 out_valid SHALL be 1 only in DONE; latency SHALL be exactly NUM_LANES/SIMD_WIDTH + 1 cycles from the acceptance edge to out_valid high.
REQ-026 out_data, out_tmask and out_tag SHALL be stable while out_valid && !out_ready.
REQ-027 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); simultaneous output fire and acceptance SHALL go DONE->BUSY with no bubble.
REQ-028 Output fire without a new acceptance SHALL return DONE->IDLE.
REQ-029 SIMD_WIDTH == NUM_LANES SHALL give a BUSY dwell of 1 cycle and a latency of 2.

Reset
REQ-030 While reset=0: state IDLE, out_valid 0, in_ready 1, cnt 0, vote registers 0, out_data/out_tmask/out_tag 0.
REQ-031 Reset asserted in BUSY or DONE SHALL abort the request immediately, with no later out_valid for it.

Verification (NUM_LANES=4, SIMD_WIDTH=2, XLEN=32)
REQ-032 ADD, tmask 1111, rs1 {1,2,3,0xFFFFFFFF}, rs2 all 1 -> out_valid 3 cycles after accept, data {2,3,4,0}.
REQ-033 SLT lane0 rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 36 -> 0xF8000000.
REQ-034 VOTE_BAL, tmask 1011, rs1 bit0 lanes0-3 {1,0,1,1} -> lanes 0,1,3 = 9, lane2 = 0; VOTE_ALL -> 0, VOTE_ANY -> 1.
REQ-035 out_ready low 5 cycles in DONE -> out_valid held, data/tag stable, in_ready 0; then out_ready=1 with in_valid=1 -> fire and accept the same cycle, next out_valid 3 cycles later.
REQ-036 reset pulled low in the second BUSY cycle -> out_valid 0 and in_ready 1 immediately; after release, the next request completes with correct data.
